// File: rtl/alu_pkg.sv
// Shared encodings for alu_muldiv: Alu_op/funct codes, decoded op, FSM states.
// Optional feature macro: ALU_DIV_EN (adds DIV/DIVU to the decoder).
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
    } op_e;

    // Map the Alu_op/funct pair onto one internal operation.
    function automatic op_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
        op_e op;
        op = OP_ILL;
        case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   op = OP_ADD;
                    F_SUB:   op = OP_SUB;
                    F_AND:   op = OP_AND;
                    F_OR:    op = OP_OR;
                    F_XOR:   op = OP_XOR;
                    F_NOR:   op = OP_NOR;
                    F_SLT:   op = OP_SLT;
                    F_SLTU:  op = OP_SLTU;
                    F_MFHI:  op = OP_MFHI;
                    F_MFLO:  op = OP_MFLO;
                    F_MULT:  op = OP_MULT;
                    F_MULTU: op = OP_MULTU;
`ifdef ALU_DIV_EN
                    F_DIV:   op = OP_DIV;
                    F_DIVU:  op = OP_DIVU;
`endif
                    default: op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

    // Operations that run on the iterative engine.
    function automatic logic op_is_muldiv(input op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_engine.sv
// Iterative one-bit-per-cycle multiplier / restoring divider with sign fix-up.
// Optional feature macro: ALU_DIV_EN (divider datapath present only when defined).
module muldiv_engine #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_step_c_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned W2    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic             busy_q, fix_q, done_q, neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d, m_q;
    logic [WIDTH-1:0] hi_q, lo_q, fix_hi_c, fix_lo_c;
    logic [WIDTH:0]   sum_c;
    logic [W2-1:0]    prod_c, prod_fix_c;
    logic             sa_c, sb_c;
    logic [WIDTH-1:0] ma_c, mb_c;

`ifdef ALU_DIV_EN
    logic             div_q, neg_r_q, div0_q, ovf_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   shift_c, diff_c;
    logic [WIDTH-1:0] quo_c, rem_c;
`else
    logic             unused_div;
    assign unused_div = div_i;
`endif

    assign last_step_c_o = busy_q && (cnt_q == LAST_CNT);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // Operand magnitudes for signed operations.
    always_comb begin
        sa_c = signed_i & a_i[WIDTH-1];
        sb_c = signed_i & b_i[WIDTH-1];
        ma_c = sa_c ? (~a_i + WIDTH'(1)) : a_i;
        mb_c = sb_c ? (~b_i + WIDTH'(1)) : b_i;
    end

    // One shift-add (mul) or restoring subtract (div) step.
    always_comb begin
        sum_c = {1'b0, acc_q[WIDTH-1:0]} + (q_q[0] ? {1'b0, m_q} : '0);
        acc_d = {1'b0, sum_c[WIDTH:1]};
        q_d   = {sum_c[0], q_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        shift_c = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff_c  = shift_c - {1'b0, m_q};
        if (div_q) begin
            if (!diff_c[WIDTH]) begin
                acc_d = diff_c;
                q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shift_c;
                q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Sign correction and special cases, producing the final HI/LO.
    always_comb begin
        prod_c     = {acc_q[WIDTH-1:0], q_q};
        prod_fix_c = neg_q ? (~prod_c + W2'(1)) : prod_c;
        fix_hi_c   = prod_fix_c[W2-1:WIDTH];
        fix_lo_c   = prod_fix_c[WIDTH-1:0];
`ifdef ALU_DIV_EN
        quo_c = neg_q   ? (~q_q + WIDTH'(1)) : q_q;
        rem_c = neg_r_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        if (div_q) begin
            if (div0_q) begin
                fix_lo_c = '1;
                fix_hi_c = a_q;
            end else if (ovf_q) begin
                fix_lo_c = a_q;
                fix_hi_c = '0;
            end else begin
                fix_lo_c = quo_c;
                fix_hi_c = rem_c;
            end
        end
`endif
    end

    // Load on start, iterate WIDTH steps, then one fix-up cycle ending in done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            fix_q   <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef ALU_DIV_EN
            div_q   <= 1'b0;
            neg_r_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                busy_q <= 1'b1;
                fix_q  <= 1'b0;
                cnt_q  <= '0;
                acc_q  <= '0;
                neg_q  <= sa_c ^ sb_c;
`ifdef ALU_DIV_EN
                div_q   <= div_i;
                neg_r_q <= sa_c;
                div0_q  <= (b_i == '0);
                ovf_q   <= signed_i && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
                a_q     <= a_i;
                q_q     <= div_i ? ma_c : mb_c;
                m_q     <= div_i ? mb_c : ma_c;
`else
                q_q     <= mb_c;
                m_q     <= ma_c;
`endif
            end else if (busy_q) begin
                acc_q <= acc_d;
                q_q   <= q_d;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_step_c_o) begin
                    busy_q <= 1'b0;
                    fix_q  <= 1'b1;
                end
            end else if (fix_q) begin
                fix_q  <= 1'b0;
                done_q <= 1'b1;
                hi_q   <= fix_hi_c;
                lo_q   <= fix_lo_c;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle MIPS ALU: single-cycle R-type ops plus iterative MULT/DIV with HI/LO.
// Optional feature macro: ALU_DIV_EN (DIV/DIVU supported when defined, illegal otherwise).
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       alu_op_i,
    input  logic [5:0]       funct_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             illegal_o
);

    state_e           state_q, state_d;
    op_e              op_q, dec_op_c;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d, alu_c;
    logic             zero_q, zero_d, done_q, done_d, illegal_q, illegal_d, ready_q;
    logic             accept_c, eng_start_c, eng_last_c, eng_done;
    logic [WIDTH-1:0] eng_hi, eng_lo;

    assign dec_op_c    = decode_op(alu_op_i, funct_i);
    assign accept_c    = start_i && ready_q;
    assign eng_start_c = accept_c && op_is_muldiv(dec_op_c);

    assign ready_o   = ready_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign done_o    = done_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign illegal_o = illegal_q;

    muldiv_engine #(.WIDTH(WIDTH)) u_engine (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (eng_start_c),
        .div_i         (op_is_div(dec_op_c)),
        .signed_i      (op_is_signed(dec_op_c)),
        .a_i           (a_i),
        .b_i           (b_i),
        .last_step_c_o (eng_last_c),
        .done_o        (eng_done),
        .hi_o          (eng_hi),
        .lo_o          (eng_lo)
    );

    // Single-cycle ALU on the captured operands.
    always_comb begin
        alu_c = '0;
        case (op_q)
            OP_ADD:  alu_c = a_q + b_q;
            OP_SUB:  alu_c = a_q - b_q;
            OP_AND:  alu_c = a_q & b_q;
            OP_OR:   alu_c = a_q | b_q;
            OP_XOR:  alu_c = a_q ^ b_q;
            OP_NOR:  alu_c = ~(a_q | b_q);
            OP_SLT:  alu_c = WIDTH'($signed(a_q) < $signed(b_q));
            OP_SLTU: alu_c = WIDTH'(a_q < b_q);
            OP_MFHI: alu_c = hi_q;
            OP_MFLO: alu_c = lo_q;
            default: alu_c = '0;
        endcase
    end

    // Next state and next output values.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = op_is_muldiv(dec_op_c) ? ST_CALC : ST_DONE;
            ST_CALC: if (eng_last_c) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: begin
                state_d   = ST_IDLE;
                illegal_d = (op_q == OP_ILL);
                if (op_is_muldiv(op_q)) begin
                    done_d   = eng_done;
                    hi_d     = eng_hi;
                    lo_d     = eng_lo;
                    result_d = eng_lo;
                end else begin
                    done_d   = 1'b1;
                    result_d = alu_c;
                end
                zero_d = (result_d == '0);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ILL;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            ready_q   <= (state_d == ST_IDLE);
            if (accept_c) begin
                op_q <= dec_op_c;
                a_q  <= a_i;
                b_q  <= b_i;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: scoreboard of predicted results per operation.
// Honours ALU_DIV_EN the same way as the design.
module tb_alu_muldiv;

    localparam int unsigned W = 32;
    localparam int unsigned MD_LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic         ready_o;
    logic [W-1:0] a_i, b_i;
    logic [1:0]   alu_op_i;
    logic [5:0]   funct_i;
    logic [W-1:0] result_o, hi_o, lo_o;
    logic         zero_o, done_o, illegal_o;

    typedef struct {
        logic [W-1:0] result, hi, lo;
        logic         illegal;
        int           lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] result, hi, lo;
        logic         zero, illegal, ready;
        int           lat;
    } obs_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic [1:0]   aop;
        logic [5:0]   fn;
    } stim_t;

    exp_t         exp_q[$];
    logic [W-1:0] mhi, mlo;
    int           n_tests = 0;
    int           n_fail  = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .alu_op_i(alu_op_i), .funct_i(funct_i),
        .result_o(result_o), .zero_o(zero_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    // Reference model: predict one operation and update the model HI/LO.
    task automatic predict(input logic [W-1:0] a, b, input logic [1:0] aop, input logic [5:0] fn);
        exp_t e;
        logic signed [63:0] ps;
        logic [63:0] pu;
        int sa, sb;
        bit md, ill;
        sa = $signed(a);
        sb = $signed(b);
        md = 0; ill = 0;
        e.result = '0;
        if (aop == 2'b00) e.result = a + b;
        else if (aop == 2'b01) e.result = a - b;
        else if (aop == 2'b11) ill = 1;
        else begin
            case (fn)
                6'b100000: e.result = a + b;
                6'b100010: e.result = a - b;
                6'b100100: e.result = a & b;
                6'b100101: e.result = a | b;
                6'b100110: e.result = a ^ b;
                6'b100111: e.result = ~(a | b);
                6'b101010: e.result = (sa < sb) ? 1 : 0;
                6'b101011: e.result = (a < b) ? 1 : 0;
                6'b010000: e.result = mhi;
                6'b010010: e.result = mlo;
                6'b011000: begin
                    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                    mhi = ps[63:32]; mlo = ps[31:0]; md = 1;
                end
                6'b011001: begin
                    pu = {32'b0, a} * {32'b0, b};
                    mhi = pu[63:32]; mlo = pu[31:0]; md = 1;
                end
`ifdef ALU_DIV_EN
                6'b011010: begin
                    md = 1;
                    if (b == 0) begin mlo = '1; mhi = a; end
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mlo = a; mhi = '0; end
                    else begin mlo = sa / sb; mhi = sa % sb; end
                end
                6'b011011: begin
                    md = 1;
                    if (b == 0) begin mlo = '1; mhi = a; end
                    else begin mlo = a / b; mhi = a % b; end
                end
`endif
                default: ill = 1;
            endcase
        end
        if (md) e.result = mlo;
        e.hi = mhi;
        e.lo = mlo;
        e.illegal = ill;
        e.lat = md ? MD_LAT : 1;
        exp_q.push_back(e);
    endtask

    // Drive one operation, push its prediction, wait (bounded) for done.
    task automatic run_op(input stim_t s, input bit poke, output obs_t o);
        int wait_cyc;
        o = '{default: 0};
        wait_cyc = 0;
        @(negedge clk);
        while (ready_o !== 1'b1 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        predict(s.a, s.b, s.aop, s.fn);
        a_i = s.a; b_i = s.b; alu_op_i = s.aop; funct_i = s.fn; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i = $urandom; b_i = $urandom;
        while (o.lat < 200) begin
            if (poke) begin
                @(negedge clk);
                start_i  = (o.lat % 3) == 0;
                alu_op_i = 2'b00;
            end
            @(posedge clk);
            #1;
            start_i = 1'b0;
            o.lat++;
            if (done_o === 1'b1) break;
        end
        o.result = result_o; o.zero = zero_o; o.illegal = illegal_o;
        o.hi = hi_o; o.lo = lo_o; o.ready = ready_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; alu_op_i = '0; funct_i = '0;
        mhi = '0; mlo = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (result_o !== '0)  begin n_fail++; $display("FAIL reset.result got=%h exp=0", result_o); end
        n_tests++; if (zero_o !== 1'b1)  begin n_fail++; $display("FAIL reset.zero got=%b exp=1", zero_o); end
        n_tests++; if (done_o !== 1'b0)  begin n_fail++; $display("FAIL reset.done got=%b exp=0", done_o); end
        n_tests++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset.illegal got=%b exp=0", illegal_o); end
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset.ready got=%b exp=1", ready_o); end
        n_tests++; if (hi_o !== '0 || lo_o !== '0) begin n_fail++; $display("FAIL reset.hilo got=%h/%h exp=0/0", hi_o, lo_o); end
    endtask

    task automatic test_alu();
        stim_t t[10];
        obs_t o;
        exp_t e;
        t[0] = '{32'd20, 32'd20, 2'b10, 6'b100000};
        t[1] = '{32'd50, 32'd50, 2'b01, 6'b000000};
        t[2] = '{32'd3, 32'd2, 2'b10, 6'b100101};
        t[3] = '{32'd3, 32'd2, 2'b10, 6'b100111};
        t[4] = '{32'hFFFF_FFFF, 32'd1, 2'b10, 6'b101010};
        t[5] = '{32'hFFFF_FFFF, 32'd1, 2'b10, 6'b101011};
        t[6] = '{32'hFFFF_FFFF, 32'd1, 2'b00, 6'b111111};
        t[7] = '{32'd7, 32'd9, 2'b10, 6'b100010};
        t[8] = '{32'hF0F0_1234, 32'h0FF0_FF00, 2'b10, 6'b100100};
        t[9] = '{32'hF0F0_1234, 32'h0FF0_FF00, 2'b10, 6'b100110};
        foreach (t[i]) begin
            run_op(t[i], 1'b0, o);
            e = exp_q.pop_front();
            n_tests++; if (o.result !== e.result) begin n_fail++; $display("FAIL alu[%0d].result got=%h exp=%h", i, o.result, e.result); end
            n_tests++; if (o.zero !== (e.result == 0)) begin n_fail++; $display("FAIL alu[%0d].zero got=%b exp=%b", i, o.zero, e.result == 0); end
            n_tests++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL alu[%0d].latency got=%0d exp=%0d", i, o.lat, e.lat); end
            n_tests++; if (o.illegal !== e.illegal) begin n_fail++; $display("FAIL alu[%0d].illegal got=%b exp=%b", i, o.illegal, e.illegal); end
        end
        n_tests++; if (t[0].a + t[0].b !== 32'd40) begin n_fail++; $display("FAIL alu.table got=%h exp=28", t[0].a + t[0].b); end
    endtask

    // Mul/div sequences issued back to back; the first op is poked with ignored starts.
    task automatic test_muldiv(input string tag, input stim_t t[8]);
        obs_t o;
        exp_t e;
        foreach (t[i]) begin
            run_op(t[i], i == 0, o);
            e = exp_q.pop_front();
            n_tests++; if (o.result !== e.result) begin n_fail++; $display("FAIL %s[%0d].result got=%h exp=%h", tag, i, o.result, e.result); end
            n_tests++; if (o.hi !== e.hi || o.lo !== e.lo) begin n_fail++; $display("FAIL %s[%0d].hilo got=%h/%h exp=%h/%h", tag, i, o.hi, o.lo, e.hi, e.lo); end
            n_tests++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL %s[%0d].latency got=%0d exp=%0d", tag, i, o.lat, e.lat); end
            n_tests++; if (o.illegal !== e.illegal) begin n_fail++; $display("FAIL %s[%0d].illegal got=%b exp=%b", tag, i, o.illegal, e.illegal); end
            n_tests++; if (o.ready !== 1'b1) begin n_fail++; $display("FAIL %s[%0d].ready_at_done got=%b exp=1", tag, i, o.ready); end
        end
    endtask

    task automatic test_mult();
        stim_t t[8];
        t[0] = '{32'hFFFF_FFFD, 32'd7, 2'b10, 6'b011000};
        t[1] = '{32'd0, 32'd0, 2'b10, 6'b010000};
        t[2] = '{32'd0, 32'd0, 2'b10, 6'b010010};
        t[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 6'b011001};
        t[4] = '{32'h8000_0000, 32'h8000_0000, 2'b10, 6'b011000};
        t[5] = '{32'h1234_5678, 32'hFEDC_BA98, 2'b10, 6'b011000};
        t[6] = '{32'd0, 32'h1234_5678, 2'b10, 6'b011001};
        t[7] = '{32'd0, 32'd0, 2'b11, 6'b011000};
        test_muldiv("mult", t);
    endtask

    task automatic test_div();
        stim_t t[8];
        t[0] = '{32'd100, 32'd7, 2'b10, 6'b011011};
        t[1] = '{32'hFFFF_FFF9, 32'd2, 2'b10, 6'b011010};
        t[2] = '{32'd5, 32'd0, 2'b10, 6'b011011};
        t[3] = '{32'hFFFF_FFFB, 32'd0, 2'b10, 6'b011010};
        t[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 6'b011010};
        t[5] = '{32'd7, 32'hFFFF_FFFE, 2'b10, 6'b011010};
        t[6] = '{32'hFFFF_FFFF, 32'd3, 2'b10, 6'b011011};
        t[7] = '{32'd0, 32'd0, 2'b10, 6'b010000};
        test_muldiv("div", t);
    endtask

    task automatic test_back_to_back();
        logic [5:0] fns[12];
        stim_t s;
        obs_t o;
        exp_t e;
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                6'b101010, 6'b101011, 6'b010000, 6'b011000, 6'b011010, 6'b011011};
        for (int i = 0; i < 14; i++) begin
            s.a = $urandom; s.b = (i % 4 == 0) ? 32'd0 : 32'($urandom);
            s.aop = (i % 7 == 6) ? 2'($urandom_range(0, 3)) : 2'b10;
            s.fn = fns[$urandom_range(0, 11)];
            run_op(s, 1'b0, o);
            e = exp_q.pop_front();
            n_tests++; if (o.result !== e.result || o.illegal !== e.illegal) begin n_fail++; $display("FAIL b2b[%0d].result got=%h/%b exp=%h/%b", i, o.result, o.illegal, e.result, e.illegal); end
            n_tests++; if (o.hi !== e.hi || o.lo !== e.lo) begin n_fail++; $display("FAIL b2b[%0d].hilo got=%h/%h exp=%h/%h", i, o.hi, o.lo, e.hi, e.lo); end
            n_tests++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL b2b[%0d].latency got=%0d exp=%0d", i, o.lat, e.lat); end
        end
    endtask

    task automatic test_reset_midop();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        a_i = 32'h0000_1234; b_i = 32'h0000_5678; alu_op_i = 2'b10; funct_i = 6'b011000; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1 if (done_o === 1'b1) seen_done++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        mhi = '0; mlo = '0;
        #1;
        n_tests++; if (hi_o !== '0 || lo_o !== '0) begin n_fail++; $display("FAIL rst_mid.hilo_async got=%h/%h exp=0/0", hi_o, lo_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (MD_LAT + 4) begin
            @(posedge clk);
            #1 if (done_o === 1'b1) seen_done++;
        end
        n_tests++; if (seen_done !== 0) begin n_fail++; $display("FAIL rst_mid.no_done got=%0d exp=0", seen_done); end
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid.ready got=%b exp=1", ready_o); end
        n_tests++; if (hi_o !== '0 || lo_o !== '0) begin n_fail++; $display("FAIL rst_mid.hilo got=%h/%h exp=0/0", hi_o, lo_o); end
        n_tests++; if (zero_o !== 1'b1 || result_o !== '0) begin n_fail++; $display("FAIL rst_mid.result got=%h/%b exp=0/1", result_o, zero_o); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_midop();
        test_back_to_back();
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard.leftover got=%0d exp=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
